// File: rtl/tpa_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tpa_reg_arbiter
//  Purpose  : Two-requester arbiter serialising read/write access from the
//             cfg-side master path (A) and the two-wire slave engine (B) onto
//             a single-port 2^AW x DW register memory. Same-cycle writes to
//             the same address are resolved in favour of A; B is retired with
//             a drop indication and the event is counted.
//  Macro    : TPA_ARB_RR_EN - defined: round-robin on non-collision ties;
//                             undefined: fixed priority, A beats B.
//  Ports    : clk, reset           clock, synchronous active-high reset
//             a_req/cmd/addr/wdata  requester A (cmd 1 = write)
//             a_ack, a_rdata        A completion pulse and read data
//             b_req/cmd/addr/wdata  requester B (same rules as A)
//             b_ack, b_rdata, b_drop B completion, read data, write dropped
//             mem_en/we/addr/wdata  registered memory strobe and payload
//             mem_rdata             memory read data (1-cycle latency)
//             busy                  high whenever the FSM is not IDLE
//             coll_cnt              saturating write-collision counter
//  Revision : 1.0  initial release
// ============================================================================
module tpa_reg_arbiter #(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          a_req,
   input  logic          a_cmd,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_ack,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_cmd,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_ack,
   output logic [DW-1:0] b_rdata,
   output logic          b_drop,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic [7:0]    coll_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RDWAIT = 2'd2,
      ACK    = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic          win_b, win_b_nxt;
   logic          mem_en_nxt, mem_we_nxt;
   logic [AW-1:0] mem_addr_nxt;
   logic [DW-1:0] mem_wdata_nxt;
   logic          a_ack_nxt, b_ack_nxt, b_drop_nxt;
   logic [DW-1:0] a_rdata_nxt, b_rdata_nxt;
   logic [7:0]    coll_cnt_nxt;

   logic          collision;
   logic          grant_b;
   logic          grant_evt;

   // Same-cycle writes to one address: A wins, B is retired without access.
   assign collision = a_req & b_req & a_cmd & b_cmd & (a_addr == b_addr);

   // A real (non-collision) grant taken from IDLE.
   assign grant_evt = (state == IDLE) & (a_req | b_req) & ~collision;

`ifdef TPA_ARB_RR_EN
   // Pointer records whether B took the last real grant; resets to B so
   // that A wins the first tie.
   logic last_b;

   assign grant_b = b_req & (~a_req | ~last_b);

   always_ff @(posedge clk) begin
      if (reset) begin
         last_b <= 1'b1;
      end else if (grant_evt) begin
         last_b <= grant_b;
      end
   end
`else
   assign grant_b = b_req & ~a_req;
`endif

   assign busy = (state != IDLE);

   always_comb begin
      state_nxt     = state;
      win_b_nxt     = win_b;
      mem_en_nxt    = 1'b0;
      mem_we_nxt    = 1'b0;
      mem_addr_nxt  = '0;
      mem_wdata_nxt = '0;
      a_ack_nxt     = 1'b0;
      b_ack_nxt     = 1'b0;
      b_drop_nxt    = 1'b0;
      a_rdata_nxt   = a_rdata;
      b_rdata_nxt   = b_rdata;
      coll_cnt_nxt  = coll_cnt;

      case (state)
         IDLE: begin
            if (collision) begin
               state_nxt     = ISSUE;
               win_b_nxt     = 1'b0;
               mem_en_nxt    = 1'b1;
               mem_we_nxt    = 1'b1;
               mem_addr_nxt  = a_addr;
               mem_wdata_nxt = a_wdata;
               // B is retired in the same cycle A's write is strobed.
               b_ack_nxt     = 1'b1;
               b_drop_nxt    = 1'b1;
               if (coll_cnt != 8'hFF) begin
                  coll_cnt_nxt = coll_cnt + 8'd1;
               end
            end else if (a_req | b_req) begin
               state_nxt     = ISSUE;
               win_b_nxt     = grant_b;
               mem_en_nxt    = 1'b1;
               mem_we_nxt    = grant_b ? b_cmd   : a_cmd;
               mem_addr_nxt  = grant_b ? b_addr  : a_addr;
               mem_wdata_nxt = grant_b ? b_wdata : a_wdata;
            end
         end
         ISSUE: begin
            // The registered mem_we holds the latched command.
            if (mem_we) begin
               state_nxt = ACK;
               a_ack_nxt = ~win_b;
               b_ack_nxt = win_b;
            end else begin
               state_nxt = RDWAIT;
            end
         end
         RDWAIT: begin
            state_nxt = ACK;
            if (win_b) begin
               b_rdata_nxt = mem_rdata;
               b_ack_nxt   = 1'b1;
            end else begin
               a_rdata_nxt = mem_rdata;
               a_ack_nxt   = 1'b1;
            end
         end
         ACK: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         win_b     <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         a_ack     <= 1'b0;
         b_ack     <= 1'b0;
         b_drop    <= 1'b0;
         a_rdata   <= '0;
         b_rdata   <= '0;
         coll_cnt  <= 8'd0;
      end else begin
         state     <= state_nxt;
         win_b     <= win_b_nxt;
         mem_en    <= mem_en_nxt;
         mem_we    <= mem_we_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         a_ack     <= a_ack_nxt;
         b_ack     <= b_ack_nxt;
         b_drop    <= b_drop_nxt;
         a_rdata   <= a_rdata_nxt;
         b_rdata   <= b_rdata_nxt;
         coll_cnt  <= coll_cnt_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tpa_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tpa_reg_arbiter
//  Purpose  : Directed self-checking bench for tpa_reg_arbiter with a
//             behavioural single-port memory (1-cycle read latency).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tpa_reg_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_req, a_cmd, b_req, b_cmd;
   logic [7:0]  a_addr, b_addr;
   logic [15:0] a_wdata, b_wdata;
   logic        a_ack, b_ack, b_drop;
   logic [15:0] a_rdata, b_rdata;
   logic        mem_en, mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        busy;
   logic [7:0]  coll_cnt;

   logic [15:0] mem [0:255];

   int total = 0;
   int bad   = 0;

   tpa_reg_arbiter #(.AW(8), .DW(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .a_req     (a_req),
      .a_cmd     (a_cmd),
      .a_addr    (a_addr),
      .a_wdata   (a_wdata),
      .a_ack     (a_ack),
      .a_rdata   (a_rdata),
      .b_req     (b_req),
      .b_cmd     (b_cmd),
      .b_addr    (b_addr),
      .b_wdata   (b_wdata),
      .b_ack     (b_ack),
      .b_rdata   (b_rdata),
      .b_drop    (b_drop),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .coll_cnt  (coll_cnt)
   );

   always #5 clk = ~clk;

   // Single-port register memory, one-cycle read latency.
   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called in an IDLE cycle with requests already presented; the expected
   // winner is is_b. Ends in the following IDLE cycle.
   task automatic read_txn(input bit is_b, input logic [7:0] ad,
                           input logic [15:0] d, input bit drop);
      step();
      chk("rd_issue_en", mem_en, 1);
      chk("rd_issue_we", mem_we, 0);
      chk("rd_issue_addr", mem_addr, ad);
      step();
      chk("rd_wait_ack", a_ack | b_ack, 0);
      step();
      chk("rd_ack_a", a_ack, !is_b);
      chk("rd_ack_b", b_ack, is_b);
      chk("rd_data", is_b ? b_rdata : a_rdata, d);
      chk("rd_no_drop", b_drop, 0);
      chk("rd_ack_mem_idle", {mem_en, mem_addr}, 0);
      if (drop) begin
         if (is_b) b_req = 1'b0;
         else      a_req = 1'b0;
      end
      step();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem_rdata = 16'h0000;
      mem[8'h10] = 16'hAAAA;
      mem[8'h20] = 16'hBBBB;
      reset = 1'b1;
      a_req = 0; a_cmd = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_cmd = 0; b_addr = 0; b_wdata = 0;
      step(); step(); step();

      // ---- reset state
      chk("rst_a_ack", a_ack, 0);
      chk("rst_b_ack", b_ack, 0);
      chk("rst_b_drop", b_drop, 0);
      chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
      chk("rst_rdata", {a_rdata, b_rdata}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_coll", coll_cnt, 0);
      reset = 1'b0;
      step();

      // ---- A writes 0x1234 to 0x05, then B reads it back
      a_req = 1; a_cmd = 1; a_addr = 8'h05; a_wdata = 16'h1234;
      step();
      chk("wr_issue_en", mem_en, 1);
      chk("wr_issue_we", mem_we, 1);
      chk("wr_issue_addr", mem_addr, 8'h05);
      chk("wr_issue_data", mem_wdata, 16'h1234);
      chk("wr_issue_busy", busy, 1);
      chk("wr_issue_ack", a_ack, 0);
      step();
      chk("wr_ack", a_ack, 1);
      chk("wr_ack_b", b_ack, 0);
      a_req = 0;
      b_req = 1; b_cmd = 0; b_addr = 8'h05;
      step();
      chk("idle_busy", busy, 0);
      read_txn(1'b1, 8'h05, 16'h1234, 1'b1);

      // ---- simultaneous reads, then an immediate repeat of the tie
      a_req = 1; a_cmd = 0; a_addr = 8'h10;
      b_req = 1; b_cmd = 0; b_addr = 8'h20;
      read_txn(1'b0, 8'h10, 16'hAAAA, 1'b0);
`ifdef TPA_ARB_RR_EN
      read_txn(1'b1, 8'h20, 16'hBBBB, 1'b1);
      read_txn(1'b0, 8'h10, 16'hAAAA, 1'b1);
`else
      read_txn(1'b0, 8'h10, 16'hAAAA, 1'b1);
      read_txn(1'b1, 8'h20, 16'hBBBB, 1'b1);
`endif

      // ---- same-cycle write collision on 0x40
      a_req = 1; a_cmd = 1; a_addr = 8'h40; a_wdata = 16'h1111;
      b_req = 1; b_cmd = 1; b_addr = 8'h40; b_wdata = 16'h2222;
      step();
      chk("coll_b_ack", b_ack, 1);
      chk("coll_b_drop", b_drop, 1);
      chk("coll_a_ack_early", a_ack, 0);
      chk("coll_wdata", mem_wdata, 16'h1111);
      chk("coll_cnt1", coll_cnt, 1);
      b_req = 0;
      step();
      chk("coll_a_ack", a_ack, 1);
      chk("coll_b_ack_off", {b_ack, b_drop}, 0);
      a_req = 0;
      step();
      chk("coll_mem40", mem[8'h40], 16'h1111);

      // ---- non-simultaneous writes to 0x40: B first, A one cycle later
      b_req = 1; b_cmd = 1; b_addr = 8'h40; b_wdata = 16'h7777;
      step();
      chk("seq_b_wdata", mem_wdata, 16'h7777);
      a_req = 1; a_cmd = 1; a_addr = 8'h40; a_wdata = 16'h8888;
      step();
      chk("seq_b_ack", b_ack, 1);
      chk("seq_b_nodrop", b_drop, 0);
      b_req = 0;
      step();
      step();
      chk("seq_a_wdata", mem_wdata, 16'h8888);
      chk("seq_coll_same", coll_cnt, 1);
      step();
      chk("seq_a_ack", a_ack, 1);
      a_req = 0;
      step();
      chk("seq_mem40", mem[8'h40], 16'h8888);

      // ---- 300 back-to-back collisions: counter saturates
      for (int i = 0; i < 300; i++) begin
         a_req = 1; a_cmd = 1; a_addr = 8'h50; a_wdata = i[15:0];
         b_req = 1; b_cmd = 1; b_addr = 8'h50; b_wdata = ~i[15:0];
         step();
         chk("sat_ack_drop", {b_ack, b_drop}, 2'b11);
         b_req = 0;
         step();
         a_req = 0;
         step();
      end
      chk("sat_coll", coll_cnt, 255);
      chk("sat_mem50", mem[8'h50], 16'd299);

      // ---- reset in RDWAIT of an A read, then a fresh read
      a_req = 1; a_cmd = 0; a_addr = 8'h10;
      step();
      step();
      reset = 1'b1;
      step();
      chk("mid_rst_ack", a_ack, 0);
      chk("mid_rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
      chk("mid_rst_rdata", a_rdata, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_coll", coll_cnt, 0);
      reset = 1'b0;
      step();
      chk("post_rst_issue", mem_en, 1);
      chk("post_rst_noack", a_ack, 0);
      step();
      chk("post_rst_wait", a_ack, 0);
      step();
      chk("post_rst_ack", a_ack, 1);
      chk("post_rst_data", a_rdata, 16'hAAAA);
      a_req = 0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tpa_reg_arbiter.md
# tpa_reg_arbiter

Two-requester arbiter that sequences access to the shared 256x16 configuration register space. Requester A is the register-protocol master path (cfg side) and requester B is the two-wire slave engine. The block serialises their read and write requests onto a single-port memory and resolves same-cycle write collisions deterministically. It sits between both protocol front-ends and the register array; neither front-end touches the array directly.

## Interface
- AW, 8, address width (register space depth 2^AW)
- DW, 16, data width
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- a_req  in  1  requester A request; held high until a_ack
- a_cmd  in  1  1 = write, 0 = read; stable while a_req high
- a_addr  in  AW  requester A address
- a_wdata  in  DW  requester A write data
- a_ack  out  1  one-cycle completion pulse to A
- a_rdata  out  DW  read data, valid in a_ack cycle, held until next A read ack
- b_req, b_cmd, b_addr, b_wdata  in  1/1/AW/DW  requester B, same rules as A
- b_ack  out  1  one-cycle completion pulse to B
- b_rdata  out  DW  read data for B, same rules as a_rdata
- b_drop  out  1  pulses with b_ack when B's write was discarded by collision
- mem_en  out  1  memory access strobe (registered)
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after mem_en with mem_we=0
- busy  out  1  high whenever state != IDLE
- coll_cnt  out  8  saturating count of write collisions

## Operation
- States: IDLE, ISSUE, RDWAIT, ACK.
- IDLE: if no req, stay. Otherwise select winner (see arbitration), latch its cmd/addr/wdata, go ISSUE.
- ISSUE: mem_en=1, mem_we=cmd, mem_addr/mem_wdata = latched values. Write: go ACK. Read: go RDWAIT.
- RDWAIT: capture mem_rdata into winner's rdata register, go ACK.
- ACK: assert winner's ack for exactly one cycle, go IDLE.
- Requesters must drop req at the edge where ack is seen. If req is still high when IDLE is re-entered, it is a new transaction.
- Arbitration (macro-dependent, see Configuration). Only one grant per IDLE visit; the loser keeps its req high and is served next.
- Collision: in IDLE, a_req & b_req & a_cmd & b_cmd & (a_addr == b_addr). A is always granted. B is retired without a memory access: b_ack=1 and b_drop=1 in the ISSUE cycle of A's write. coll_cnt increments, saturating at 255. A collision does not update the round-robin pointer.
- Non-simultaneous writes to the same address are not collisions. They execute in grant order, and the last write wins.
- Read-after-write from either side returns the newly written value, since accesses are strictly serialised.
- Memory outputs are all zero whenever mem_en=0.

## Timing
- Reset values: a_ack=b_ack=b_drop=0, a_rdata=b_rdata=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, busy=0, coll_cnt=0, state IDLE. Round-robin pointer marks B as last granted, so A wins the first tie.
- Request sampled at edge k (IDLE):
  - Write: mem_en high in cycle k+1, ack in cycle k+2.
  - Read: mem_en high in k+1, rdata captured at k+3, ack in cycle k+3.
- Loser of a tie: earliest ack is the winner's ack cycle + 3 (write) or + 4 (read).
- Reset mid-operation:
  - Transaction abandoned, no ack issued.
  - mem_en low from the next cycle.
  - A write already strobed at the reset edge may complete in memory. A write still in IDLE/ISSUE-latch stage is not performed.

## Configuration
- TPA_ARB_RR_EN defined: round-robin. On a non-collision tie, grant the requester not granted last. The pointer updates on every real grant.
- TPA_ARB_RR_EN undefined: fixed priority, A always beats B on ties. No pointer register exists.
- Collision handling and coll_cnt are identical in both builds.

## Test plan
- Reset, then A writes 0x1234 to addr 0x05. Then B reads 0x05 → a_ack at k+2; b_ack at its k+3 with b_rdata=0x1234; b_drop=0.
- A and B read 0x10 / 0x20 in the same cycle, mem preloaded 0xAAAA / 0xBBBB → a_ack first with a_rdata=0xAAAA, then b_ack with b_rdata=0xBBBB. Repeat the tie immediately → with TPA_ARB_RR_EN B is served first; without it A is served first.
- Same-cycle writes to 0x40, A=0x1111, B=0x2222 → b_ack+b_drop in cycle k+1, a_ack at k+2, memory[0x40]=0x1111, coll_cnt=1.
- B writes 0x7777 to 0x40 and is granted, then A writes 0x8888 to 0x40 one cycle later → no drop, coll_cnt unchanged, memory[0x40]=0x8888.
- 300 back-to-back collisions → coll_cnt stops at 255, every b_ack paired with b_drop.
- Assert reset in the RDWAIT cycle of an A read → no a_ack, all outputs zero next cycle. Deassert reset with a_req still high → fresh read acked 3 cycles later.
